// File: rtl/rv32i_pkg.sv
// +----------------------------------------------------------------------+
// | rv32i_pkg : shared RV32I constants for the memory-access stage       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;
  localparam logic [2:0] C_F3_SB  = 3'b000;
  localparam logic [2:0] C_F3_SH  = 3'b001;
  localparam logic [2:0] C_F3_SW  = 3'b010;

  localparam logic C_EXC_MISALIGNED = 1'b0;
  localparam logic C_EXC_ILLEGAL    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align : store lane/byte-enable generation, load extract/extend   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_be,
  output logic [XLEN-1:0] st_lanes,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // funct3[1:0] encodes access size identically for loads and stores
  always_comb begin
    st_be    = 4'b1111;
    st_lanes = st_data;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << st_offset;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {st_offset[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_offset)
      2'd0:    w_byte = ld_rdata[7:0];
      2'd1:    w_byte = ld_rdata[15:8];
      2'd2:    w_byte = ld_rdata[23:16];
      default: w_byte = ld_rdata[31:24];
    endcase
    w_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      C_F3_LB:  ld_data = {{24{w_byte[7]}}, w_byte};
      C_F3_LH:  ld_data = {{16{w_half[15]}}, w_half};
      C_F3_LBU: ld_data = {24'd0, w_byte};
      C_F3_LHU: ld_data = {16'd0, w_half};
      default:  ld_data = ld_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit : RV32I data-memory access stage, one txn in flight  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic            exc_cause,
  output logic [XLEN-1:0] exc_addr
);

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  logic            w_legal;
  logic            w_misaligned;
  logic            w_accept;
  logic            w_fault;
  logic [2:0]      r_funct3;
  logic [1:0]      r_offset;
  logic [4:0]      r_rd;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_lanes;
  logic [XLEN-1:0] w_ld_data;

  lsu_align u_align (
    .st_funct3 (ex_funct3),
    .st_offset (ex_addr[1:0]),
    .st_data   (ex_wdata),
    .st_be     (w_st_be),
    .st_lanes  (w_st_lanes),
    .ld_funct3 (r_funct3),
    .ld_offset (r_offset),
    .ld_rdata  (dmem_rdata),
    .ld_data   (w_ld_data)
  );

  always_comb begin
    w_legal = 1'b0;
    if (ex_load && !ex_store) begin
      case (ex_funct3)
        C_F3_LB, C_F3_LH, C_F3_LW, C_F3_LBU, C_F3_LHU: w_legal = 1'b1;
        default: ;
      endcase
    end else if (ex_store && !ex_load) begin
      case (ex_funct3)
        C_F3_SB, C_F3_SH, C_F3_SW: w_legal = 1'b1;
        default: ;
      endcase
    end
    w_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                   ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
  end

  always_comb begin
    w_state_nxt = r_state;
    ex_ready    = 1'b0;
    w_accept    = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && (ex_load || ex_store)) begin
          if (!w_legal || w_misaligned) begin
            w_fault = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ:  if (dmem_gnt) w_state_nxt = dmem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (dmem_rvalid) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= 1'b0;
      exc_addr   <= '0;
      r_funct3   <= 3'd0;
      r_offset   <= 2'd0;
      r_rd       <= 5'd0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (w_accept) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ex_store;
        dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
        dmem_be    <= w_st_be;
        dmem_wdata <= w_st_lanes;
        r_funct3   <= ex_funct3;
        r_offset   <= ex_addr[1:0];
        r_rd       <= ex_rd;
      end
      if ((r_state == ST_REQ) && dmem_gnt) dmem_req <= 1'b0;
      // illegal outranks misaligned when both apply
      if (w_fault) begin
        exc_valid <= 1'b1;
        exc_cause <= w_legal ? C_EXC_MISALIGNED : C_EXC_ILLEGAL;
        exc_addr  <= ex_addr;
      end
      if ((r_state == ST_WAIT) && dmem_rvalid) begin
        wb_valid <= 1'b1;
        wb_rd    <= r_rd;
        wb_data  <= w_ld_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit : scoreboard bench for load_store_unit            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid, exc_valid, exc_cause;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int acc; bit seen; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int acc; bit chk_lat; } wb_t;
  typedef struct { logic cause; logic [31:0] addr; int acc; } exc_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  exc_t exc_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [31:0] mem [logic [31:0]];

  int   force_gnt = -1, force_rv = -1;
  int   req_cnt = 0, gnt_lat = 0, rv_dly = 0;
  bit   rv_pending = 1'b0;
  logic [31:0] rv_addr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit is_legal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld && !st) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (st && !ld) return f3 <= 3'd2;
    return 1'b0;
  endfunction

  // Memory: random grant latency, random read latency, stray gnt/rvalid when idle
  always @(negedge clk) begin
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    if (rv_pending) begin
      if (rv_dly == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = mem_word(rv_addr);
        rv_pending  = 1'b0;
      end else begin
        rv_dly--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      dmem_rvalid = 1'b1;
    end
    if (dmem_req) begin
      if (req_cnt == 0) gnt_lat = (force_gnt >= 0) ? force_gnt : int'($urandom_range(0, 2));
      if (req_cnt >= gnt_lat) begin
        dmem_gnt = 1'b1;
        req_cnt  = 0;
        if (!dmem_we) begin
          rv_pending = 1'b1;
          rv_addr    = dmem_addr;
          rv_dly     = (force_rv >= 0) ? force_rv : int'($urandom_range(0, 3));
        end
      end else begin
        req_cnt++;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      dmem_gnt = 1'b1;
    end
  end

  // Monitor: compares every presented output against the scoreboard queues
  always @(negedge clk) begin
    req_t r;
    wb_t  w;
    exc_t e;
    #1;
    if (rst_n) begin
      if (wb_valid && exc_valid) check("wb_exc_overlap", {31'd0, exc_valid}, 32'd0);
      if (dmem_req) begin
        if (req_q.size() == 0) begin
          check("req_spurious", {31'd0, dmem_req}, 32'd0);
        end else begin
          r = req_q[0];
          check("req_we", {31'd0, dmem_we}, {31'd0, r.we});
          check("req_addr", dmem_addr, r.addr);
          check("req_be", {28'd0, dmem_be}, {28'd0, r.be});
          if (r.we) check("req_wdata", dmem_wdata, r.wdata);
          if (!r.seen) begin
            check("req_latency", cyc - r.acc, 32'd0);
            req_q[0].seen = 1'b1;
          end
          if (dmem_gnt) void'(req_q.pop_front());
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          check("wb_spurious", {31'd0, wb_valid}, 32'd0);
        end else begin
          w = wb_q.pop_front();
          check("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
          check("wb_data", wb_data, w.data);
          if (w.chk_lat) check("wb_latency", cyc - w.acc, 32'd2);
        end
      end
      if (exc_valid) begin
        if (exc_q.size() == 0) begin
          check("exc_spurious", {31'd0, exc_valid}, 32'd0);
        end else begin
          e = exc_q.pop_front();
          check("exc_cause", {31'd0, exc_cause}, {31'd0, e.cause});
          check("exc_addr", exc_addr, e.addr);
          check("exc_latency", cyc - e.acc, 32'd0);
        end
      end
    end
  end

  task automatic finish_now(input string why);
    $display("FAIL %s: bound expired (cycle %0d)", why, cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "aborted");
  endtask

  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input bit chk_lat);
    int n = 0;
    int sz, off;
    logic [63:0] v, mask;
    req_t r;
    wb_t  w;
    exc_t e;
    while (!ex_ready && n < 100) begin
      ex_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!ex_ready) finish_now("ex_ready_wait");
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    if (ld || st) begin
      sz  = 1 << f3[1:0];
      off = int'(addr[1:0]);
      if (!is_legal(ld, st, f3)) begin
        e.cause = 1'b1; e.addr = addr; e.acc = cyc + 1; exc_q.push_back(e);
      end else if ((off % sz) != 0) begin
        e.cause = 1'b0; e.addr = addr; e.acc = cyc + 1; exc_q.push_back(e);
      end else begin
        r.we = st; r.addr = addr & ~32'h3; r.acc = cyc + 1; r.seen = 1'b0;
        r.be = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
        req_q.push_back(r);
        if (ld) begin
          v = {32'd0, mem_word(r.addr)} >> (8 * off);
          if (sz < 4) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
          end
          w.rd = rd; w.data = v[31:0]; w.acc = cyc + 1; w.chk_lat = chk_lat;
          wb_q.push_back(w);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    ex_valid = 1'b0;
    while ((req_q.size() != 0 || wb_q.size() != 0 || exc_q.size() != 0 || !ex_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n, (n < 200) ? n : 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ex_ready"}, {31'd0, ex_ready}, 32'd1);
    check({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    check({tag, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
    check({tag, "_dmem_be"}, {28'd0, dmem_be}, 32'd0);
    check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd0);
    check({tag, "_exc_cause"}, {31'd0, exc_cause}, 32'd0);
    check({tag, "_exc_addr"}, exc_addr, 32'd0);
  endtask

  initial begin
    int n;
    int sel;
    bit ld, st;
    #2;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store word with one-cycle-late grant
    force_gnt = 1; force_rv = 0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF, 5'd0, 1'b0);
    drain();

    // Zero-wait byte/half loads with sign and zero extension
    force_gnt = 0;
    mem[32'h1000] = 32'h80FF_0000;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 1'b1);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 5'd8, 1'b1);
    drain();
    mem[32'h1000] = 32'h8001_1234;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'd0, 5'd9, 1'b1);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'd0, 5'd10, 1'b1);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 5'd11, 1'b1);
    drain();

    // Faults back-to-back, then byte store and an ignored non-memory op
    issue(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'd0, 5'd1, 1'b0);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 5'd2, 1'b0);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'd0, 5'd3, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'd0, 5'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_2001, 32'd0, 5'd0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_2002, 32'h0000_00A5, 5'd0, 1'b0);
    issue(1'b0, 1'b0, 3'b010, 32'h0000_2001, 32'd0, 5'd4, 1'b0);
    drain();

    // Reset while waiting for read data; the late rvalid must be dropped
    force_gnt = 0; force_rv = 6;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 5'd3, 1'b0);
    ex_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!rv_pending && n < 50);
    if (!rv_pending) finish_now("reset_setup");
    rst_n = 1'b0;
    void'(wb_q.pop_back());
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    force_gnt = -1; force_rv = -1;
    repeat (10) @(negedge clk);
    check("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("post_rst_req", {31'd0, dmem_req}, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      ld  = (sel == 1) || (sel >= 2 && sel <= 5);
      st  = (sel == 1) || (sel >= 6);
      issue(ld, st, 3'($urandom_range(0, 7)), {16'd0, 16'($urandom)}, $urandom,
            5'($urandom_range(0, 31)), 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        ex_valid = 1'b0;
        @(negedge clk);
      end
    end
    drain();
    check("req_q_left", req_q.size(), 32'd0);
    check("wb_q_left", wb_q.size(), 32'd0);
    check("exc_q_left", exc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    finish_now("watchdog");
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage for the RV32I core: consumes the effective address produced by the execute-stage `adder_subtractor` (rs1 + imm), issues one data-memory transaction per load/store over a request/grant/rvalid handshake, and returns aligned, sign- or zero-extended load data to writeback. One transaction is outstanding at a time; misaligned or illegal accesses never reach memory.

## Interface
- `XLEN`, 32, data/address width (only 32 supported)
- `clk` in 1, system clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `ex_valid` in 1, execute stage presents an operation
- `ex_ready` out 1, unit can accept (high only in IDLE)
- `ex_load` / `ex_store` in 1, operation type (both low: not a memory op; both high: illegal)
- `ex_funct3` in 3, RV32I width/sign field
- `ex_addr` in XLEN, effective address (adder sum)
- `ex_wdata` in XLEN, store data (rs2)
- `ex_rd` in 5, load destination register
- `dmem_req` out 1, request valid; `dmem_we` out 1, write
- `dmem_addr` out XLEN, word address (bits [1:0] = 0)
- `dmem_be` out 4, byte enables; `dmem_wdata` out XLEN, lane-replicated store data
- `dmem_gnt` in 1, request accepted; `dmem_rvalid` in 1, read data valid; `dmem_rdata` in XLEN
- `wb_valid` out 1, one-cycle load result pulse; `wb_rd` out 5; `wb_data` out XLEN
- `exc_valid` out 1, one-cycle fault pulse; `exc_cause` out 1 (0 misaligned, 1 illegal); `exc_addr` out XLEN

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: `ex_ready`=1. On `ex_valid` with exactly one of load/store: decode funct3 (loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010). Other codes or load&store both high -> illegal fault. Halfword with addr[0]=1 or word with addr[1:0]≠0 -> misaligned fault (illegal takes priority). Fault: pulse `exc_*` next cycle, stay IDLE, no request. Else latch op/addr/data/rd, go REQ. `ex_valid` with neither load nor store: ignored.
- REQ: `dmem_req`=1; addr/we/be/wdata held stable until `dmem_gnt`. On gnt: store -> IDLE; load -> WAIT.
- WAIT: on `dmem_rvalid` select byte (addr[1:0]) or halfword (addr[1]), sign-extend (LB/LH) or zero-extend (LBU/LHU), register into `wb_data`, pulse `wb_valid`, go IDLE.
- Byte enables: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111; loads also drive matching `dmem_be`. Store data: byte replicated ×4, half ×2.
- `dmem_rvalid` outside WAIT, `dmem_gnt` outside REQ: ignored.

## Timing
- Reset (async, any state): state IDLE; `dmem_req`, `dmem_we`, `dmem_be`, `wb_valid`, `exc_valid`, `exc_cause` = 0; `dmem_addr`, `dmem_wdata`, `wb_data`, `wb_rd`, `exc_addr` = 0. In-flight transaction abandoned; late rvalid after reset ignored.
- Accept at edge N -> `dmem_req` high cycle N+1 (registered). Zero-wait memory: gnt in N+1, rvalid in N+2, `wb_valid` in N+3. Store completes at gnt edge; next accept possible at N+2.
- Fault: `exc_valid` high in cycle N+1 only; `ex_ready` stays 1, back-to-back accept permitted.
- `wb_valid` and `exc_valid` never assert in the same cycle.

## Structure
- Shared package `rv32i_pkg`: funct3 load/store constants, LSU state encoding, exception-cause constants, `XLEN`.
- Sub-module `lsu_align` (combinational): store lane/byte-enable generation and load extraction/extension; FSM and registers in `load_store_unit`.

## Test plan
- SW addr 0x0000_1008, data 0xDEAD_BEEF, gnt one cycle late -> req held 2 cycles, be 1111, addr 0x1008, wdata 0xDEADBEEF, no wb.
- LB addr 0x1003, rdata 0x80FF_0000 -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080; be 1000.
- LH addr 0x1002, rdata 0x8001_1234 -> wb_data 0xFFFF_8001; LHU -> 0x0000_8001, wb_rd matches.
- LW addr 0x1001 -> exc_valid, cause 0, exc_addr 0x1001, dmem_req never asserts; funct3 011 load -> cause 1.
- SB addr 0x2002 data 0x0000_00A5 -> be 0100, wdata 0xA5A5_A5A5, addr 0x2000.
- Reset asserted in WAIT, rvalid arrives after release -> no wb_valid, state IDLE, ex_ready 1.
